// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the X-interface dispatcher: FSM state
// encoding, response field widths and a winner-selection helper.
package cv32e40p_pkg;

  localparam int unsigned X_RD_WIDTH   = 5;
  localparam int unsigned X_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    DISP_OFFER = 1'b0,
    DISP_DONE  = 1'b1
  } disp_state_e;

  // Index of the lowest set bit of a vector of up to four requesters.
  // An all-zero vector returns 0; callers qualify the result separately.
  function automatic int unsigned lowest_set_idx(input logic [3:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_fifo.sv
// Small in-order FIFO with occupancy count. Pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two. Push while full and pop while empty
// are ignored.
module cv32e40p_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1'b1);
    end
  endfunction

  assign full_o  = (count_r == CNT_W'(DEPTH));
  assign empty_o = (count_r == {CNT_W{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so stale indices never reappear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/cv32e40p_x_dispatcher.sv
// Offers each core X-interface instruction to every coprocessor, collects
// their accept decisions, reports the lowest-index accepter to the core and
// keeps write-back offloads in order so results return in issue order.
module cv32e40p_x_dispatcher
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_COPROC = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  // core request
  input  logic                                    x_valid_i,
  output logic                                    x_ready_o,
  input  logic [2:0][31:0]                        x_rs_i,
  input  logic [2:0]                              x_rs_valid_i,
  input  logic                                    x_rd_clean_i,
  output logic                                    x_accept_o,
  output logic                                    x_is_mem_op_o,
  output logic                                    x_writeback_o,
  // core response
  output logic                                    x_rvalid_o,
  input  logic                                    x_rready_i,
  output logic [X_RD_WIDTH-1:0]                   x_rd_o,
  output logic [X_DATA_WIDTH-1:0]                 x_data_o,
  output logic                                    x_error_o,
  // coprocessor request
  output logic [NUM_COPROC-1:0]                   cp_valid_o,
  input  logic [NUM_COPROC-1:0]                   cp_ready_i,
  output logic [2:0][31:0]                        cp_rs_o,
  output logic [2:0]                              cp_rs_valid_o,
  output logic                                    cp_rd_clean_o,
  input  logic [NUM_COPROC-1:0]                   cp_accept_i,
  input  logic [NUM_COPROC-1:0]                   cp_is_mem_op_i,
  input  logic [NUM_COPROC-1:0]                   cp_writeback_i,
  // coprocessor response
  input  logic [NUM_COPROC-1:0]                   cp_rvalid_i,
  output logic [NUM_COPROC-1:0]                   cp_rready_o,
  input  logic [NUM_COPROC-1:0][X_RD_WIDTH-1:0]   cp_rd_i,
  input  logic [NUM_COPROC-1:0][X_DATA_WIDTH-1:0] cp_data_i,
  input  logic [NUM_COPROC-1:0]                   cp_error_i,
  // status
  output logic [$clog2(DEPTH+1)-1:0]              outstanding_o,
  output logic                                    accept_conflict_o
);

  localparam int unsigned IDX_W = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;

  disp_state_e           state_r;
  disp_state_e           state_s;
  logic [NUM_COPROC-1:0] done_r;
  logic [NUM_COPROC-1:0] acc_r;
  logic [NUM_COPROC-1:0] mem_r;
  logic [NUM_COPROC-1:0] wb_r;
  logic [NUM_COPROC-1:0] hs_s;
  logic                  all_done_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [3:0]            acc4_s;
  logic [IDX_W-1:0]      win_s;
  logic [IDX_W-1:0]      head_s;

  // Operands travel to all coprocessors unchanged.
  assign cp_rs_o       = x_rs_i;
  assign cp_rs_valid_o = x_rs_valid_i;
  assign cp_rd_clean_o = x_rd_clean_i;

  assign hs_s       = cp_valid_o & cp_ready_i;
  assign all_done_s = &(done_r | hs_s);

  // Offer to every coprocessor that has not answered yet, unless the ordering FIFO is full.
  always_comb begin
    cp_valid_o = {NUM_COPROC{1'b0}};
    if ((state_r == DISP_OFFER) && x_valid_i && !full_s) begin
      cp_valid_o = ~done_r;
    end else begin
      cp_valid_o = {NUM_COPROC{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= DISP_OFFER;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: leave OFFER once every coprocessor has answered; DONE lasts one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      DISP_OFFER: begin
        if (all_done_s) begin
          state_s = DISP_DONE;
        end else begin
          state_s = DISP_OFFER;
        end
      end
      DISP_DONE: state_s = DISP_OFFER;
      default:   state_s = DISP_OFFER;
    endcase
  end

  // Capture each coprocessor's answer at its handshake; a dropped x_valid_i keeps them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r <= {NUM_COPROC{1'b0}};
      acc_r  <= {NUM_COPROC{1'b0}};
      mem_r  <= {NUM_COPROC{1'b0}};
      wb_r   <= {NUM_COPROC{1'b0}};
    end else if (state_r == DISP_DONE) begin
      done_r <= {NUM_COPROC{1'b0}};
      acc_r  <= {NUM_COPROC{1'b0}};
      mem_r  <= {NUM_COPROC{1'b0}};
      wb_r   <= {NUM_COPROC{1'b0}};
    end else begin
      done_r <= done_r | hs_s;
      acc_r  <= (acc_r & ~hs_s) | (cp_accept_i & hs_s);
      mem_r  <= (mem_r & ~hs_s) | (cp_is_mem_op_i & hs_s);
      wb_r   <= (wb_r & ~hs_s) | (cp_writeback_i & hs_s);
    end
  end

  // Winner is the lowest-index accepter.
  always_comb begin
    acc4_s = 4'b0000;
    for (int k = 0; k < int'(NUM_COPROC); k++) begin
      acc4_s[k] = acc_r[k];
    end
    win_s = IDX_W'(lowest_set_idx(acc4_s));
  end

  assign x_ready_o         = (state_r == DISP_DONE);
  assign x_accept_o        = x_ready_o & (|acc_r);
  assign x_writeback_o     = x_accept_o & wb_r[win_s];
  assign x_is_mem_op_o     = x_accept_o & mem_r[win_s];
  assign accept_conflict_o = x_ready_o & ((acc_r & (acc_r - NUM_COPROC'(1'b1))) != {NUM_COPROC{1'b0}});
  assign push_s            = x_writeback_o;
  assign pop_s             = x_rvalid_o & x_rready_i;

  cv32e40p_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (win_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .count_o (outstanding_o)
  );

  // Forward the response of the head coprocessor only; all others stay back-pressured.
  always_comb begin
    x_rvalid_o  = 1'b0;
    x_rd_o      = {X_RD_WIDTH{1'b0}};
    x_data_o    = {X_DATA_WIDTH{1'b0}};
    x_error_o   = 1'b0;
    cp_rready_o = {NUM_COPROC{1'b0}};
    if (!empty_s) begin
      x_rvalid_o = cp_rvalid_i[head_s];
      x_rd_o     = cp_rd_i[head_s];
      x_data_o   = cp_data_i[head_s];
      x_error_o  = cp_error_i[head_s];
      for (int k = 0; k < int'(NUM_COPROC); k++) begin
        cp_rready_o[k] = (head_s == IDX_W'(k)) & x_rready_i;
      end
    end else begin
      x_rvalid_o  = 1'b0;
      cp_rready_o = {NUM_COPROC{1'b0}};
    end
  end

endmodule

// File: doc/cv32e40p_x_dispatcher.md
CV32E40P_X_DISPATCHER -- requirements
Module: cv32e40p_x_dispatcher

Interface
REQ-001 SHALL have parameter NUM_COPROC, default 2: number of coprocessor ports, legal range 1..4.
REQ-002 SHALL have parameter DEPTH, default 4: maximum outstanding write-back offloads, legal range 1..8.
REQ-003 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have core request ports:
- x_valid_i in 1; x_ready_o out 1
- x_rs_i in 3x32; x_rs_valid_i in 3; x_rd_clean_i in 1
- x_accept_o out 1; x_is_mem_op_o out 1; x_writeback_o out 1
REQ-006 SHALL have core response ports: x_rvalid_o out 1; x_rready_i in 1; x_rd_o out 5; x_data_o out 32; x_error_o out 1.
REQ-007 SHALL have coprocessor request ports:
- cp_valid_o out NUM_COPROC; cp_ready_i in NUM_COPROC
- cp_rs_o out 3x32; cp_rs_valid_o out 3; cp_rd_clean_o out 1
- cp_accept_i, cp_is_mem_op_i, cp_writeback_i: in, NUM_COPROC each
REQ-008 SHALL have coprocessor response ports: cp_rvalid_i in NUM_COPROC; cp_rready_o out NUM_COPROC; cp_rd_i in NUM_COPROCx5; cp_data_i in NUM_COPROCx32; cp_error_i in NUM_COPROC.
REQ-009 SHALL have status ports: outstanding_o out clog2(DEPTH+1) (FIFO occupancy); accept_conflict_o out 1 (one-cycle pulse).

Function
REQ-010 SHALL implement a two-state FSM, OFFER and DONE, with a per-coprocessor done[] vector.
REQ-011 In OFFER: cp_valid_o[k] = x_valid_i & ~full & ~done[k]; cp_rs_o, cp_rs_valid_o and cp_rd_clean_o pass through combinationally from the core.
REQ-012 On cp_valid_o[k] & cp_ready_i[k]: set done[k]; register cp_accept_i[k], cp_is_mem_op_i[k] and cp_writeback_i[k].
REQ-013 When all done[] bits are set, counting handshakes in the current cycle, the FSM SHALL enter DONE on the next edge.
REQ-014 In DONE, for exactly one cycle:
- x_ready_o=1
- x_accept_o = OR of registered accepts
- winner = lowest-index accepter
- x_writeback_o and x_is_mem_op_o come from the winner (both 0 if no accepter)
- clear done[]; return to OFFER
REQ-015 Minimum request latency: x_valid_i with all cp_ready_i high in cycle 0 -> x_ready_o in cycle 1; x_ready_o SHALL be 0 in every other cycle.
REQ-016 More than one accepter SHALL pulse accept_conflict_o in the DONE cycle; only the winner is recorded.
REQ-017 In DONE, if x_accept_o & x_writeback_o, the winner index SHALL be pushed to an in-order FIFO of depth DEPTH.
REQ-018 full = (occupancy==DEPTH); while full, no cp_valid_o SHALL assert, so the FIFO never overflows.
REQ-019 The FIFO head h selects the response source:
- x_rvalid_o = ~empty & cp_rvalid_i[h]
- x_rd_o, x_data_o, x_error_o come from coprocessor h
- cp_rready_o[k] = ~empty & (k==h) & x_rready_i
REQ-020 The FIFO SHALL pop on x_rvalid_o & x_rready_i.
REQ-021 cp_rvalid_i from any non-head coprocessor SHALL be ignored, with its cp_rready_o held 0.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-024 Deassertion of x_valid_i before x_ready_o is a protocol violation; the FSM SHALL keep its done[] state and resume offering when x_valid_i reasserts.

Reset
REQ-025 On rst_ni low, asynchronously:
- FSM=OFFER; done[]=0; FIFO empty; outstanding_o=0
- x_ready_o, x_accept_o, x_writeback_o, x_is_mem_op_o, accept_conflict_o, x_rvalid_o = 0
- all cp_valid_o and cp_rready_o = 0
REQ-026 Reset mid-offer or with entries outstanding SHALL discard all state; no response SHALL be forwarded until a new accepted write-back offload.

Structure
REQ-027 The FSM state enum and the response-field widths (rd 5, data 32) SHALL reside in cv32e40p_pkg.
REQ-028 The ordering FIFO SHALL be an instance of cv32e40p_fifo, with data width max(1,$clog2(NUM_COPROC)) and depth DEPTH.

Verification
REQ-029 NUM_COPROC=2, both ready, cp1 accepts with writeback -> x_ready_o in cycle 1, x_accept_o=1, x_writeback_o=1, outstanding_o=1.
REQ-030 cp0 ready in cycle 0, cp1 ready in cycle 3 -> cp_valid_o[0] low from cycle 1, x_ready_o in cycle 4 only.
REQ-031 cp0 and cp1 both accept -> winner cp0, accept_conflict_o=1 for one cycle, FIFO head=0.
REQ-032 DEPTH=2, three accepted writeback offloads with no responses -> third offer held (cp_valid_o=0) until one response pops.
REQ-033 Outstanding order cp1,cp0; cp0 raises rvalid first with data 0xA5 -> ignored; cp1 data 0x5A forwarded first, then 0xA5.
REQ-034 rst_ni pulsed low with 2 outstanding -> outstanding_o=0, x_rvalid_o=0 immediately, before the next clock edge.
